cby_param_shadow: RTL and testbench
===================================

Name: cby_param_shadow

Overview:
- Parametrised Y-channel connection block, successor to the fixed-size cby tiles.
- Passes CHAN_WIDTH vertical tracks straight through in both directions.
- Drives NUM_IPIN grid input pins, each through a MUX_SIZE:1 routing mux.
- Mux selects come from a serial configuration chain with a shadow (commit) register, so shifting never disturbs live routing. A bit counter reports chain-load completion.

Parameters:
- CHAN_WIDTH, 9, tracks per direction.
- NUM_IPIN, 4, grid input pins driven.
- MUX_SIZE, 6, inputs per ipin mux; must be even and at least 2.
- TRACK_STRIDE, 1, track offset between consecutive ipins.
- SEL_W, derived as clog2(MUX_SIZE), select bits per mux. Not user-set.
- CHAIN_LEN, derived as NUM_IPIN*SEL_W, configuration bits.

Ports:
- prog_clk  input  1  configuration/register clock
- prog_reset  input  1  synchronous active-high reset
- chany_bottom_in  input  CHAN_WIDTH  tracks entering from bottom
- chany_top_in  input  CHAN_WIDTH  tracks entering from top
- chany_bottom_out  output  CHAN_WIDTH  tracks leaving to bottom
- chany_top_out  output  CHAN_WIDTH  tracks leaving to top
- ipin_out  output  NUM_IPIN  grid pin drives
- ccff_head  input  1  serial config data in
- ccff_en  input  1  shift enable
- ccff_commit  input  1  copy chain to shadow
- ccff_tail  output  1  serial config data out
- cfg_done  output  1  chain fully loaded since last reset/commit

Behaviour:
- Clock and reset: single clock prog_clk. Reset prog_reset is synchronous, active-high, sampled on the rising edge of prog_clk.
- Pass-through: chany_top_out[t] = chany_bottom_in[t]; chany_bottom_out[t] = chany_top_in[t]. Purely combinational, unaffected by reset.
- Mux input mapping: input k of ipin i uses track p = (i*TRACK_STRIDE + k/2) mod CHAN_WIDTH. Even k selects chany_bottom_in[p]; odd k selects chany_top_in[p].
- Chain shift: chain register chain[0:CHAIN_LEN-1]. On a prog_clk edge with ccff_en=1:
  - chain[0] <= ccff_head;
  - chain[j] <= chain[j-1] for j>0.
  - ccff_tail = chain[CHAIN_LEN-1], registered, no extra latency.
  - A bit entered at cycle n appears on ccff_tail after CHAIN_LEN shifts.
- Shadow register: shadow[0:CHAIN_LEN-1]. On an edge with ccff_commit=1, shadow <= chain.
- Select decode: sel_i = shadow[i*SEL_W +: SEL_W], with LSB = shadow[i*SEL_W]. The ipin mux selects input sel_i. If sel_i >= MUX_SIZE, ipin_out[i] = 0.
- Mux path: combinational from the channel inputs to ipin_out; the select changes only on a commit edge.
- Bit counter: cnt is clog2(CHAIN_LEN+1) bits.
  - Increments on each ccff_en edge and saturates at CHAIN_LEN.
  - cfg_done = (cnt == CHAIN_LEN), registered.
  - Commit clears cnt to 0 on the same edge.
- Simultaneous ccff_en and ccff_commit: shadow captures the pre-shift chain and the chain shifts. The counter clears, then counts the concurrent shift, so cnt = 1.
- Reset values: chain=0, shadow=0, cnt=0, cfg_done=0, ccff_tail=0. After reset every sel_i = 0, so ipin_out[i] = chany_bottom_in[(i*TRACK_STRIDE) mod CHAN_WIDTH].
- Reset priority: reset overrides ccff_en and ccff_commit on the same edge. Reset mid-load discards partial chain contents.
- Shifting without commit leaves ipin_out routing unchanged, with no glitch from config activity.

Optional Feature:
- Macro: CBY_IPIN_REG_EN.
- Defined: ipin_out is registered on prog_clk, with one cycle of latency from a channel input or commit to the pin. The register resets to 0 on prog_reset.
- Undefined: ipin_out is combinational as above.
- The pass-through and config paths are identical in both builds.

Test Plan:
- Reset check (defaults, CHAIN_LEN=12): assert prog_reset one cycle with chany_bottom_in=9'h0AA and chany_top_in=9'h155. Require ipin_out bits = bottom_in[0..3], i.e. ipin_out=4'b1010 (LSB = ipin0). Require cfg_done=0, ccff_tail=0, chany_top_out=9'h0AA, chany_bottom_out=9'h155.
- Load and commit: shift 12 bits so that sel = 5,1,3,2 (ipin0..3), then pulse commit.
  - cfg_done=1 after the 12th shift and 0 after commit.
  - ipin0=top_in[2], ipin1=top_in[1], ipin2=top_in[3], ipin3=bottom_in[4].
  - Toggle each source track and check that the pin follows.
- Shift without commit: reload the chain with alternate selects and do not commit. Require ipin_out unchanged through 12 shifts. Then commit and require the new routing.
- Chain flow-through: shift in the pattern 1 followed by zeros. Require ccff_tail=1 exactly on the edge after the 12th shift, and the counter holding 12.
- Out-of-range and simultaneous events:
  - sel=6 or 7 on ipin1 forces ipin_out[1]=0.
  - ccff_en with ccff_commit on the same edge: shadow gets the old chain, cnt=1.
  - prog_reset during shifting clears everything.
- CBY_IPIN_REG_EN build: repeat the load-and-commit scenario. Require each pin change one prog_clk later than in the combinational build, and ipin_out=0 after reset.

Source files
------------

// File: rtl/cby_param_shadow.sv
// cby_param_shadow: Y-channel connection block with shadowed serial config; define CBY_IPIN_REG_EN to register ipin_out
module cby_param_shadow #(
    parameter int CHAN_WIDTH   = 9,
    parameter int NUM_IPIN     = 4,
    parameter int MUX_SIZE     = 6,
    parameter int TRACK_STRIDE = 1
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
    input  logic [CHAN_WIDTH-1:0] chany_top_in,
    output logic [CHAN_WIDTH-1:0] chany_bottom_out,
    output logic [CHAN_WIDTH-1:0] chany_top_out,
    output logic [NUM_IPIN-1:0]   ipin_out,
    input  logic                  ccff_head,
    input  logic                  ccff_en,
    input  logic                  ccff_commit,
    output logic                  ccff_tail,
    output logic                  cfg_done
);
    localparam int SEL_W     = $clog2(MUX_SIZE);
    localparam int CHAIN_LEN = NUM_IPIN * SEL_W;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0] chain_q, chain_d, shadow_q, shadow_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 cfg_done_q, cfg_done_d;
    logic [NUM_IPIN-1:0]  mux_o;
`ifdef CBY_IPIN_REG_EN
    logic [NUM_IPIN-1:0]  ipin_q, ipin_d;
`endif

    assign chany_top_out    = chany_bottom_in;
    assign chany_bottom_out = chany_top_in;
    assign ccff_tail        = chain_q[CHAIN_LEN-1];
    assign cfg_done         = cfg_done_q;

    // mux inputs padded to a power of two; unused codes read as 0
    for (genvar i = 0; i < NUM_IPIN; i++) begin : g_pin
        logic [2**SEL_W-1:0] mux_in;
        for (genvar k = 0; k < 2**SEL_W; k++) begin : g_in
            localparam int P = (i * TRACK_STRIDE + k / 2) % CHAN_WIDTH;
            assign mux_in[k] = (k >= MUX_SIZE) ? 1'b0 :
                               (k % 2 == 1) ? chany_top_in[P] : chany_bottom_in[P];
        end
        assign mux_o[i] = mux_in[shadow_q[i*SEL_W +: SEL_W]];
    end

    always_comb begin
        chain_d    = ccff_en ? CHAIN_LEN'({chain_q, ccff_head}) : chain_q;
        shadow_d   = ccff_commit ? chain_q : shadow_q;
        cnt_d      = ccff_commit ? CNT_W'(ccff_en) :
                     (ccff_en && !cfg_done_q) ? cnt_q + CNT_W'(1) : cnt_q;
        cfg_done_d = cnt_d == CNT_W'(CHAIN_LEN);
`ifdef CBY_IPIN_REG_EN
        ipin_d     = mux_o;
`endif
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            chain_q    <= '0;
            shadow_q   <= '0;
            cnt_q      <= '0;
            cfg_done_q <= 1'b0;
`ifdef CBY_IPIN_REG_EN
            ipin_q     <= '0;
`endif
        end else begin
            chain_q    <= chain_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
            cfg_done_q <= cfg_done_d;
`ifdef CBY_IPIN_REG_EN
            ipin_q     <= ipin_d;
`endif
        end
    end

`ifdef CBY_IPIN_REG_EN
    assign ipin_out = ipin_q;
`else
    assign ipin_out = mux_o;
`endif
endmodule

// File: tb/tb_cby_param_shadow.sv
// tb_cby_param_shadow: directed vectors for cby_param_shadow at default parameters
module tb_cby_param_shadow;
    logic       prog_clk = 1'b0;
    logic       prog_reset, ccff_head, ccff_en, ccff_commit;
    logic [8:0] chany_bottom_in, chany_top_in, chany_bottom_out, chany_top_out;
    logic [3:0] ipin_out;
    logic       ccff_tail, cfg_done;
    int         errs = 0;
    int         checks = 0;

    always #5 prog_clk = ~prog_clk;

    cby_param_shadow dut (
        .prog_clk(prog_clk),
        .prog_reset(prog_reset),
        .chany_bottom_in(chany_bottom_in),
        .chany_top_in(chany_top_in),
        .chany_bottom_out(chany_bottom_out),
        .chany_top_out(chany_top_out),
        .ipin_out(ipin_out),
        .ccff_head(ccff_head),
        .ccff_en(ccff_en),
        .ccff_commit(ccff_commit),
        .ccff_tail(ccff_tail),
        .cfg_done(cfg_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        ccff_head = b;
        ccff_en = 1'b1;
        tick();
        ccff_en = 1'b0;
        ccff_head = 1'b0;
    endtask

    task automatic load(input logic [11:0] v);
        for (int j = 11; j >= 0; j--) shift_bit(v[j]);
    endtask

    task automatic commit();
        ccff_commit = 1'b1;
        tick();
        ccff_commit = 1'b0;
    endtask

    // registered build: pin still shows old value, then new one a cycle later
    task automatic pin(input string tag, input logic [3:0] old, input logic [3:0] exp);
        #1;
`ifdef CBY_IPIN_REG_EN
        check({tag, "_lag"}, ipin_out, old);
        tick();
`endif
        check(tag, ipin_out, exp);
    endtask

    initial begin
        prog_reset = 1'b1;
        ccff_en = 1'b0;
        ccff_commit = 1'b0;
        ccff_head = 1'b0;
        chany_bottom_in = 9'h0AA;
        chany_top_in = 9'h155;
        tick();
        prog_reset = 1'b0;
        pin("rst_ipin", 4'b0000, 4'b1010);
        check("rst_done", cfg_done, 0);
        check("rst_tail", ccff_tail, 0);
        check("top_out", chany_top_out, 9'h0AA);
        check("bottom_out", chany_bottom_out, 9'h155);

        // sel = 5,1,3,2
        for (int j = 11; j >= 0; j--) begin
            shift_bit(12'h4CD >> j);
            if (j == 1) check("done_11", cfg_done, 0);
        end
        check("done_12", cfg_done, 1);
        check("pre_commit", ipin_out, 4'b1010);
        commit();
        check("done_commit", cfg_done, 0);
        pin("route", 4'b1010, 4'b0001);
        chany_top_in = 9'h151;
        pin("tog_top2", 4'b0001, 4'b0000);
        chany_top_in = 9'h153;
        pin("tog_top1", 4'b0000, 4'b0010);
        chany_top_in = 9'h15B;
        pin("tog_top3", 4'b0010, 4'b0110);
        chany_bottom_in = 9'h0BA;
        pin("tog_bot4", 4'b0110, 4'b1110);
        chany_bottom_in = 9'h0BB;
        pin("tog_unused", 4'b1110, 4'b1110);
        check("top_out2", chany_top_out, 9'h0BB);

        // sel = 0,4,1,5 shifted in without commit
        for (int j = 11; j >= 0; j--) begin
            shift_bit(12'hA60 >> j);
            check("hold", ipin_out, 4'b1110);
        end
        commit();
        pin("new_route", 4'b1110, 4'b0011);

        for (int n = 1; n <= 12; n++) begin
            shift_bit(n == 1);
            if (n == 11) check("tail_11", ccff_tail, 0);
        end
        check("tail_12", ccff_tail, 1);
        check("done_flow", cfg_done, 1);
        shift_bit(1'b0);
        check("tail_13", ccff_tail, 0);
        check("done_sat", cfg_done, 1);

        chany_bottom_in = 9'h1FF;
        chany_top_in = 9'h1FF;
        pin("all_ones", 4'b0011, 4'b1111);
        load(12'h030);
        commit();
        pin("sel6", 4'b1111, 4'b1101);
        load(12'h038);
        commit();
        pin("sel7", 4'b1101, 4'b1101);

        chany_top_in = 9'h000;
        pin("bot_only", 4'b1101, 4'b1101);
        load(12'h249);
        check("done_pre_sim", cfg_done, 1);
        ccff_head = 1'b0;
        ccff_en = 1'b1;
        ccff_commit = 1'b1;
        tick();
        ccff_en = 1'b0;
        ccff_commit = 1'b0;
        check("done_sim", cfg_done, 0);
        pin("sim_shadow", 4'b1101, 4'b0000);
        for (int n = 1; n <= 11; n++) begin
            shift_bit(1'b0);
            if (n == 10) check("sim_cnt_10", cfg_done, 0);
        end
        check("sim_cnt_11", cfg_done, 1);

        for (int n = 0; n < 5; n++) shift_bit(1'b1);
        prog_reset = 1'b1;
        ccff_en = 1'b1;
        ccff_commit = 1'b1;
        ccff_head = 1'b1;
        tick();
        prog_reset = 1'b0;
        ccff_en = 1'b0;
        ccff_commit = 1'b0;
        ccff_head = 1'b0;
        check("rst2_done", cfg_done, 0);
        check("rst2_tail", ccff_tail, 0);
        pin("rst2_ipin", 4'b0000, 4'b1111);
        for (int n = 1; n <= 12; n++) begin
            shift_bit(1'b0);
            check("rst2_flush", ccff_tail, 0);
        end
        check("rst2_done12", cfg_done, 1);
        commit();
        pin("rst2_commit", 4'b1111, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
